// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   ADDR_W : PC / instruction-memory address width
//   BR_W   : branch target width (zero-extended to ADDR_W)
//   STEP   : PC increment per fetched instruction
//   PC_MAX : last fetchable address; the PC saturates here
//   state_e: sequencer FSM states
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int BR_W   = 16;
  localparam int STEP   = 4;
  localparam logic [ADDR_W-1:0] PC_MAX = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_e;

  // Zero-extend a branch target to a full PC.
  function automatic logic [ADDR_W-1:0] br_ext(input logic [BR_W-1:0] t);
    return {{(ADDR_W-BR_W){1'b0}}, t};
  endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: branch redirect, decode handshake and
// instruction-memory request/ack.
//   master : environment side (drives branch/stall/memory response)
//   slave  : sequencer side (drives memory request and decode slot)
interface fetch_sequencer_if;
  import fetch_pkg::*;
  logic              branch_en;
  logic [BR_W-1:0]   branch_target;
  logic              stall;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;

  modport master (
    output branch_en, branch_target, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, halted
  );
  modport slave (
    input  branch_en, branch_target, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, halted
  );
endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register.
//   clk, reset  : clock, synchronous active-high reset (pc -> 0)
//   pre_i       : preload with pre_val_i (highest priority after reset)
//   load_i      : branch load with load_val_i
//   inc_i       : advance by STEP, saturating at PC_MAX
//   pc_o        : current PC
//   at_max_o    : PC has reached PC_MAX
module pc_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pre_i,
  input  logic [ADDR_W-1:0] pre_val_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              at_max_o
);
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset)                     pc_q <= '0;
    else if (pre_i)                pc_q <= pre_val_i;
    else if (load_i)               pc_q <= load_val_i;
    else if (inc_i && !at_max_o)   pc_q <= pc_q + ADDR_W'(STEP);
  end

  assign pc_o     = pc_q;
  assign at_max_o = (pc_q >= PC_MAX);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/ack
// handshake, applies branch redirects (discarding wrong-path returns) and
// holds one fetched instruction for decode behind a valid/stall handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_sequencer_if.slave (branch, decode slot, imem)
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fetch_sequencer_if.slave bus
);
  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              halt_q, halt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              pc_load, pc_inc, at_max;
  logic [ADDR_W-1:0] pc, br_tgt;
  // Preload path is tied off in the design; it exists so the PC can be
  // seeded externally (e.g. to exercise saturation at PC_MAX).
  logic              pc_pre;
  logic [ADDR_W-1:0] pc_pre_val;
  assign pc_pre     = 1'b0;
  assign pc_pre_val = '0;

  assign br_tgt = br_ext(bus.branch_target);

  pc_reg u_pc (
    .clk        (clk),
    .reset      (reset),
    .pre_i      (pc_pre),
    .pre_val_i  (pc_pre_val),
    .load_i     (pc_load),
    .load_val_i (br_tgt),
    .inc_i      (pc_inc),
    .pc_o       (pc),
    .at_max_o   (at_max)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    halt_d  = halt_q;
    tgt_d   = tgt_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;

    // Slot drains in any state; a branch always kills it (branch wins).
    if (vld_q && !bus.stall) vld_d = 1'b0;
    if (bus.branch_en) begin
      vld_d   = 1'b0;
      pc_load = 1'b1;
    end

    unique case (state_q)
      IDLE, DRAIN, HALT: begin
        if (bus.branch_en) begin
          halt_d  = 1'b0;
          req_d   = 1'b1;
          addr_d  = br_tgt;
          state_d = REQ;
        end else if (state_q == IDLE || (state_q == DRAIN && vld_q && !bus.stall)) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.branch_en) begin
            // Returned word is wrong-path; request stays up at the target.
            addr_d = br_tgt;
          end else begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc;
            vld_d   = 1'b1;
            req_d   = 1'b0;
            if (at_max) begin
              halt_d  = 1'b1;
              state_d = HALT;
            end else begin
              pc_inc  = 1'b1;
              state_d = DRAIN;
            end
          end
        end else if (bus.branch_en) begin
          // Request cannot be retracted: remember target, wait for ack.
          tgt_d   = br_tgt;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.branch_en) tgt_d = br_tgt;
        if (bus.imem_ack) begin
          addr_d  = bus.branch_en ? br_tgt : tgt_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      halt_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      halt_q  <= halt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = vld_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
  assign bus.halted    = halt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Inputs change #1 after the rising
// edge and outputs are sampled at the same point.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] instr,
                         input logic [31:0] ipc, input logic halt);
    chk({tag, ".req"},   32'(bus.imem_req),  32'(req));
    chk({tag, ".addr"},  bus.imem_addr,      addr);
    chk({tag, ".vld"},   32'(bus.if_valid),  32'(vld));
    chk({tag, ".instr"}, bus.if_instr,       instr);
    chk({tag, ".pc"},    bus.if_pc,          ipc);
    chk({tag, ".halt"},  32'(bus.halted),    32'(halt));
  endtask

  initial begin
    reset = 1'b1;
    bus.branch_en = 1'b0; bus.branch_target = '0; bus.stall = 1'b0;
    bus.imem_ack = 1'b0;  bus.imem_rdata = '0;
    tick(); tick();
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    reset = 1'b0;

    // ---- zero-wait fetch: addr 0,4,8,12; slot pulses every 2 cycles
    tick();
    chk_all("zw.req0", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hA000_0000;
    tick(); bus.imem_ack = 0;
    chk_all("zw.slot0", 0, 32'h0, 1, 32'hA000_0000, 32'h0, 0);
    tick();
    chk_all("zw.req4", 1, 32'h4, 0, 32'hA000_0000, 32'h0, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hA000_0004;
    tick(); bus.imem_ack = 0;
    chk_all("zw.slot4", 0, 32'h4, 1, 32'hA000_0004, 32'h4, 0);
    tick();
    chk_all("zw.req8", 1, 32'h8, 0, 32'hA000_0004, 32'h4, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hA000_0008;
    tick(); bus.imem_ack = 0;
    chk_all("zw.slot8", 0, 32'h8, 1, 32'hA000_0008, 32'h8, 0);
    tick();
    chk_all("zw.req12", 1, 32'hC, 0, 32'hA000_0008, 32'h8, 0);

    // ---- reset, then stalled decode
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all("rst2", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    bus.imem_ack = 1; bus.imem_rdata = 32'hB000_0000;
    tick(); bus.imem_ack = 0; bus.stall = 1;
    chk_all("st.slot0", 0, 32'h0, 1, 32'hB000_0000, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("st.hold", 0, 32'h0, 1, 32'hB000_0000, 32'h0, 0);
    end
    bus.stall = 0;
    tick();
    chk_all("st.req4", 1, 32'h4, 0, 32'hB000_0000, 32'h0, 0);

    // ---- mid-request branch: addr 8 outstanding, ack 3 cycles later
    bus.imem_ack = 1; bus.imem_rdata = 32'hB000_0004;
    tick(); bus.imem_ack = 0;
    tick();
    chk_all("mb.req8", 1, 32'h8, 0, 32'hB000_0004, 32'h4, 0);
    bus.branch_en = 1; bus.branch_target = 16'h0100;
    tick(); bus.branch_en = 0;
    chk_all("mb.flush1", 1, 32'h8, 0, 32'hB000_0004, 32'h4, 0);
    tick();
    chk_all("mb.flush2", 1, 32'h8, 0, 32'hB000_0004, 32'h4, 0);
    tick();
    bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick(); bus.imem_ack = 0;
    chk_all("mb.req100", 1, 32'h100, 0, 32'hB000_0004, 32'h4, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hC000_0100;
    tick(); bus.imem_ack = 0;
    chk_all("mb.slot100", 0, 32'h100, 1, 32'hC000_0100, 32'h100, 0);

    // ---- branch coincident with ack
    tick();
    chk_all("ba.req104", 1, 32'h104, 0, 32'hC000_0100, 32'h100, 0);
    bus.branch_en = 1; bus.branch_target = 16'h0040;
    bus.imem_ack = 1; bus.imem_rdata = 32'hBAD0_0104;
    tick(); bus.branch_en = 0; bus.imem_ack = 0;
    chk_all("ba.req40", 1, 32'h40, 0, 32'hC000_0100, 32'h100, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hD000_0040;
    tick(); bus.imem_ack = 0;
    chk_all("ba.slot40", 0, 32'h40, 1, 32'hD000_0040, 32'h40, 0);

    // ---- saturation: seed PC with PC_MAX while the slot is stalled
    bus.stall = 1;
    force dut.pc_pre = 1'b1;
    force dut.pc_pre_val = 32'hFFFF_FFFC;
    tick();
    release dut.pc_pre;
    release dut.pc_pre_val;
    bus.stall = 0;
    tick();
    chk_all("sat.req", 1, 32'hFFFF_FFFC, 0, 32'hD000_0040, 32'h40, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hE000_FFFC;
    tick(); bus.imem_ack = 0;
    chk_all("sat.slot", 0, 32'hFFFF_FFFC, 1, 32'hE000_FFFC, 32'hFFFF_FFFC, 1);
    tick();
    chk_all("sat.drain", 0, 32'hFFFF_FFFC, 0, 32'hE000_FFFC, 32'hFFFF_FFFC, 1);
    tick();
    chk_all("sat.hold", 0, 32'hFFFF_FFFC, 0, 32'hE000_FFFC, 32'hFFFF_FFFC, 1);
    bus.branch_en = 1; bus.branch_target = 16'h0000;
    tick(); bus.branch_en = 0;
    chk_all("sat.exit", 1, 32'h0, 0, 32'hE000_FFFC, 32'hFFFF_FFFC, 0);

    // ---- reset while FLUSH waits for ack; late ack in IDLE ignored
    bus.branch_en = 1; bus.branch_target = 16'h0200;
    tick(); bus.branch_en = 0;
    chk_all("rf.flush", 1, 32'h0, 0, 32'hE000_FFFC, 32'hFFFF_FFFC, 0);
    reset = 1;
    tick(); reset = 0;
    chk_all("rf.reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'h7777_7777;
    tick(); bus.imem_ack = 0;
    chk_all("rf.idleack", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    bus.imem_ack = 1; bus.imem_rdata = 32'hF000_0000;
    tick(); bus.imem_ack = 0;
    chk_all("rf.slot0", 0, 32'h0, 1, 32'hF000_0000, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
